// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the 16-bit accumulator datapath: sequences each instruction
// through FETCH/DECODE/MEM/EXEC/WB states, drives all datapath strobes, counts retirements.
module multicycle_control_fsm #(
  parameter int         CNT_W   = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       Opcode,
  input  logic             isZero,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemAddrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             AccWrite,
  output logic             AccSrc,
  output logic             Halted,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM_RD = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    MEM_WR = 3'd5,
    BRANCH = 3'd6,
    HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_LI    = 4'h6;
  localparam logic [3:0] OP_ADDI  = 4'h7;
  localparam logic [3:0] OP_BEQZ  = 4'h8;
  localparam logic [3:0] OP_BNEZ  = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= FETCH;
      op_q    <= 4'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= Opcode;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // DECODE steers from the live Opcode port; op_q only becomes valid after this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (Opcode == HALT_OP)       state_d = HALT;
        else if (Opcode <= OP_LOAD)  state_d = MEM_RD;
        else if (Opcode == OP_STORE) state_d = MEM_WR;
        else if (Opcode <= OP_ADDI)  state_d = EXEC;
        else if (Opcode <= OP_JUMP)  state_d = BRANCH;
        else                         state_d = FETCH;
      end
      MEM_RD: state_d = (op_q == OP_LOAD) ? WB : EXEC;
      EXEC:   state_d = WB;
      WB:     state_d = FETCH;
      MEM_WR: state_d = FETCH;
      BRANCH: state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign retire = (state_d == FETCH) &&
                  (state_q == DECODE || state_q == WB || state_q == MEM_WR || state_q == BRANCH);

  // Reset masks every strobe combinationally so an aborted instruction writes nothing.
  always_comb begin
    PCWrite    = 1'b0;
    PCSource   = 2'b00;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemAddrSrc = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    AccWrite   = 1'b0;
    AccSrc     = 1'b0;
    if (!Reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        MEM_RD: begin
          MemRead    = 1'b1;
          MemAddrSrc = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          if (op_q <= 4'h3) begin
            ALUSrcB = 2'b01;
            ALUOp   = op_q[2:0];
          end else if (op_q == OP_ADDI) begin
            ALUSrcB = 2'b10;
            ALUOp   = ALU_ADD;
          end else if (op_q == OP_LI) begin
            ALUSrcB = 2'b10;
            ALUOp   = ALU_PASSB;
          end
        end
        WB: begin
          AccWrite = 1'b1;
          AccSrc   = (op_q == OP_LOAD);
        end
        MEM_WR: begin
          MemWrite   = 1'b1;
          MemAddrSrc = 1'b1;
        end
        BRANCH: begin
          PCSource = 2'b01;
          PCWrite  = (op_q == OP_JUMP) || ((op_q == OP_BEQZ) && isZero) ||
                     ((op_q == OP_BNEZ) && !isZero);
        end
        default: ;
      endcase
    end
  end

  assign Halted     = !Reset && (state_q == HALT);
  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class state by state and
// compares the full strobe vector, state, halt flag and retire count against hand-written values.
module tb_multicycle_control_fsm;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Opcode = 4'h0;
  logic        isZero = 1'b0;
  logic        PCWrite, IRWrite, MemRead, MemWrite, MemAddrSrc, ALUSrcA, AccWrite, AccSrc, Halted;
  logic [1:0]  PCSource, ALUSrcB;
  logic [2:0]  ALUOp, State;
  logic [15:0] InstrCount;

  int checks = 0;
  int fails  = 0;

  multicycle_control_fsm #(.CNT_W(16), .HALT_OP(4'hF)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .isZero(isZero),
    .PCWrite(PCWrite), .PCSource(PCSource), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemAddrSrc(MemAddrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .AccWrite(AccWrite), .AccSrc(AccSrc), .Halted(Halted), .State(State),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  // Field order: PCWrite PCSource IRWrite MemRead MemWrite MemAddrSrc ALUSrcA ALUSrcB ALUOp AccWrite AccSrc
  logic [14:0] ctl;
  logic [18:0] obs;
  assign ctl = {PCWrite, PCSource, IRWrite, MemRead, MemWrite, MemAddrSrc, ALUSrcA, ALUSrcB,
                ALUOp, AccWrite, AccSrc};
  assign obs = {Halted, State, ctl};

  localparam logic [14:0] C_NONE  = 15'd0;
  localparam logic [14:0] C_FETCH = {1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [14:0] C_MEMRD = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [14:0] C_E_ADD = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [14:0] C_E_SUB = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b001, 1'b0, 1'b0};
  localparam logic [14:0] C_E_LI  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b100, 1'b0, 1'b0};
  localparam logic [14:0] C_E_ADI = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0};
  localparam logic [14:0] C_WB    = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [14:0] C_WB_LD = {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1};
  localparam logic [14:0] C_MEMWR = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [14:0] C_BR_T  = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [14:0] C_BR_NT = {1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, C_NONE}) begin
      fails++;
      $display("FAIL reset_hold: obs=%b required %b", obs, {1'b0, 3'd0, C_NONE});
    end
    checks++;
    if (InstrCount !== 16'd0) begin
      fails++;
      $display("FAIL reset_count: count=%0d required 0", InstrCount);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 3'd0, C_FETCH}) begin
      fails++;
      $display("FAIL reset_release_fetch: obs=%b required %b", obs, {1'b0, 3'd0, C_FETCH});
    end
  endtask

  task automatic test_li();
    logic [18:0] ev [4];
    ev = '{{1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd3, C_E_LI}, {1'b0, 3'd4, C_WB}};
    Opcode = 4'h6;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL li step %0d: obs=%b required %b", i, obs, ev[i]);
      end
      if (i == 3) begin
        checks++;
        if (InstrCount !== 16'd0) begin
          fails++;
          $display("FAIL li_count_before: count=%0d required 0", InstrCount);
        end
      end
      tick();
    end
    checks++;
    if (State !== 3'd0 || InstrCount !== 16'd1) begin
      fails++;
      $display("FAIL li_retire: state=%0d count=%0d required state 0 count 1", State, InstrCount);
    end
  endtask

  task automatic test_add();
    logic [18:0] ev [5];
    ev = '{{1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd2, C_MEMRD},
           {1'b0, 3'd3, C_E_ADD}, {1'b0, 3'd4, C_WB}};
    Opcode = 4'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL add step %0d: obs=%b required %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (State !== 3'd0 || InstrCount !== 16'd2) begin
      fails++;
      $display("FAIL add_retire: state=%0d count=%0d required state 0 count 2", State, InstrCount);
    end
  endtask

  task automatic test_branch();
    logic [18:0] ev [3];
    for (int t = 0; t < 2; t++) begin
      isZero = (t == 0);
      ev = '{{1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd6, (t == 0) ? C_BR_T : C_BR_NT}};
      Opcode = 4'h8;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs !== ev[i]) begin
          fails++;
          $display("FAIL beqz z=%0d step %0d: obs=%b required %b", isZero, i, obs, ev[i]);
        end
        tick();
      end
      checks++;
      if (State !== 3'd0 || InstrCount !== 16'(3 + t)) begin
        fails++;
        $display("FAIL beqz_retire z=%0d: state=%0d count=%0d required state 0 count %0d",
                 isZero, State, InstrCount, 3 + t);
      end
    end
    isZero = 1'b0;
  endtask

  task automatic test_store();
    logic [18:0] ev [3];
    ev = '{{1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd5, C_MEMWR}};
    Opcode = 4'h5;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL store step %0d: obs=%b required %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (obs !== {1'b0, 3'd0, C_FETCH} || InstrCount !== 16'd5) begin
      fails++;
      $display("FAIL store_retire: obs=%b count=%0d required %b count 5",
               obs, InstrCount, {1'b0, 3'd0, C_FETCH});
    end
  endtask

  task automatic test_halt();
    Opcode = 4'hF;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== {1'b1, 3'd7, C_NONE} || InstrCount !== 16'd5) begin
        fails++;
        $display("FAIL halt cycle %0d: obs=%b count=%0d required %b count 5",
                 i, obs, InstrCount, {1'b1, 3'd7, C_NONE});
      end
      tick();
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b0, 3'd7, C_NONE}) begin
      fails++;
      $display("FAIL halt_reset_comb: obs=%b required %b", obs, {1'b0, 3'd7, C_NONE});
    end
    tick();
    checks++;
    if (State !== 3'd0 || InstrCount !== 16'd0 || Halted !== 1'b0) begin
      fails++;
      $display("FAIL halt_exit: state=%0d count=%0d halted=%b required 0 0 0", State, InstrCount, Halted);
    end
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_exec();
    logic [18:0] ev [4];
    ev = '{{1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd2, C_MEMRD}, {1'b0, 3'd3, C_E_SUB}};
    Opcode = 4'h1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL sub step %0d: obs=%b required %b", i, obs, ev[i]);
      end
      if (i < 3) tick();
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b0, 3'd3, C_NONE}) begin
      fails++;
      $display("FAIL sub_abort_mask: obs=%b required %b", obs, {1'b0, 3'd3, C_NONE});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd0, C_NONE} || InstrCount !== 16'd0) begin
      fails++;
      $display("FAIL sub_abort_state: obs=%b count=%0d required %b count 0",
               obs, InstrCount, {1'b0, 3'd0, C_NONE});
    end
    Reset = 1'b0;
    Opcode = 4'hB;
    #1;
    checks++;
    if (obs !== {1'b0, 3'd0, C_FETCH}) begin
      fails++;
      $display("FAIL nop_fetch: obs=%b required %b", obs, {1'b0, 3'd0, C_FETCH});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 3'd1, C_NONE}) begin
      fails++;
      $display("FAIL nop_decode: obs=%b required %b", obs, {1'b0, 3'd1, C_NONE});
    end
    tick();
    checks++;
    if (State !== 3'd0 || InstrCount !== 16'd1) begin
      fails++;
      $display("FAIL nop_retire: state=%0d count=%0d required state 0 count 1", State, InstrCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] ev [14];
    logic [3:0]  ops [14];
    logic        zs  [14];
    // ADDI (port switched to LOAD after DECODE), LOAD, BNEZ not-zero, JUMP with isZero=1
    ev = '{{1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd3, C_E_ADI}, {1'b0, 3'd4, C_WB},
           {1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd2, C_MEMRD}, {1'b0, 3'd4, C_WB_LD},
           {1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd6, C_BR_T},
           {1'b0, 3'd0, C_FETCH}, {1'b0, 3'd1, C_NONE}, {1'b0, 3'd6, C_BR_T}};
    ops = '{4'h7, 4'h7, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h9, 4'h9, 4'h9, 4'hA, 4'hA, 4'hA};
    zs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 14; i++) begin
      Opcode = ops[i];
      isZero = zs[i];
      #1;
      checks++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL b2b step %0d: obs=%b required %b", i, obs, ev[i]);
      end
      tick();
    end
    checks++;
    if (State !== 3'd0 || InstrCount !== 16'd5) begin
      fails++;
      $display("FAIL b2b_retire: state=%0d count=%0d required state 0 count 5", State, InstrCount);
    end
    isZero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_li();
    test_add();
    test_branch();
    test_store();
    test_halt();
    test_reset_mid_exec();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
